// File: rtl/gate_boy_pkg.sv
// Shared types for the IDU scheduler: IDU op encoding, data width and
// scheduler FSM states.
package gate_boy_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int IDU_WIDTH  = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDU_NOP = 2'd0,
      INC16   = 2'd1,
      DEC16   = 2'd2
   } idu_ops_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } idu_sched_state_t;

endpackage

// File: rtl/idu_rr_arbiter.sv
// Combinational requester picker: round-robin from rr_ptr with wrap, or
// lowest valid index when RR_EN=0.
module idu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter bit RR_EN   = 1'b1
) (
   input  logic [NUM_REQ-1:0]         valid,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         winner,
   output logic [$clog2(NUM_REQ)-1:0] win_idx,
   output logic                       any_valid
);

   localparam int IW = $clog2(NUM_REQ);

   always_comb begin
      int unsigned base;
      int unsigned j;
      winner    = '0;
      win_idx   = '0;
      any_valid = 1'b0;
      base      = RR_EN ? int'(rr_ptr) : 0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = base + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_valid && valid[j]) begin
            any_valid = 1'b1;
            winner[j] = 1'b1;
            win_idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/idu_scheduler.sv
// Time-shares the single 16-bit IDU between NUM_REQ requesters: arbitrate,
// hold the op for one M-cycle capture, then return result with a done pulse.
module idu_scheduler
   import gate_boy_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter bit RR_EN   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        m_tick,
   input  logic [NUM_REQ-1:0]          req,
   input  idu_ops_t [NUM_REQ-1:0]      req_op,
   input  logic [NUM_REQ-1:0][15:0]    req_operand,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          done,
   output logic [15:0]                 result,
   output logic                        busy,
   output idu_ops_t                    idu_opcode,
   output logic [15:0]                 idu_operand,
   input  logic [15:0]                 idu_result
);

   localparam int IW = $clog2(NUM_REQ);

   idu_sched_state_t   state_q, state_d;
   logic [NUM_REQ-1:0] valid;
   logic [NUM_REQ-1:0] winner;
   logic [IW-1:0]      win_idx;
   logic               any_valid;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      idx_q;
   idu_ops_t           op_q;
   logic [15:0]        opnd_q;

   // An IDU_NOP op is treated exactly like a dropped request.
   always_comb begin
      valid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         valid[i] = req[i] && (req_op[i] != IDU_NOP);
   end

   idu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .RR_EN   (RR_EN)
   ) u_arb (
      .valid     (valid),
      .rr_ptr    (rr_ptr),
      .winner    (winner),
      .win_idx   (win_idx),
      .any_valid (any_valid)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = ISSUE;
         ISSUE:   if (m_tick)    state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt     <= '0;
         done    <= '0;
         result  <= '0;
         rr_ptr  <= '0;
         idx_q   <= '0;
         op_q    <= IDU_NOP;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt     <= '0;
         done    <= '0;
         case (state_q)
            IDLE: if (any_valid) begin
               idx_q  <= win_idx;
               op_q   <= req_op[win_idx];
               opnd_q <= req_operand[win_idx];
               gnt    <= winner;
            end
            CAPTURE: begin
               result       <= idu_result;
               done[idx_q]  <= 1'b1;
            end
            RESP: if (RR_EN)
               rr_ptr <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            default: ;
         endcase
      end
   end

   // IDU inputs are idle-clean outside ISSUE so a stray m_tick captures nothing useful.
   assign idu_opcode  = (state_q == ISSUE) ? op_q   : IDU_NOP;
   assign idu_operand = (state_q == ISSUE) ? opnd_q : 16'h0000;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_idu_scheduler.sv
// Bench for idu_scheduler: one round-robin and one fixed-priority instance,
// each with a simple IDU model, a per-cycle transaction model and directed tests.
module tb_idu_scheduler;
   import gate_boy_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_tick = 1'b0;

   logic [N-1:0]         req         [2];
   idu_ops_t [N-1:0]     req_op      [2];
   logic [N-1:0][15:0]   req_operand [2];
   logic [N-1:0]         gnt         [2];
   logic [N-1:0]         done        [2];
   logic [15:0]          result      [2];
   logic                 busy        [2];
   idu_ops_t             idu_opcode  [2];
   logic [15:0]          idu_operand [2];
   logic [15:0]          idu_result  [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      idu_scheduler #(
         .NUM_REQ (N),
         .RR_EN   (g == 0 ? 1'b1 : 1'b0)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .m_tick      (m_tick),
         .req         (req[g]),
         .req_op      (req_op[g]),
         .req_operand (req_operand[g]),
         .gnt         (gnt[g]),
         .done        (done[g]),
         .result      (result[g]),
         .busy        (busy[g]),
         .idu_opcode  (idu_opcode[g]),
         .idu_operand (idu_operand[g]),
         .idu_result  (idu_result[g])
      );

      // IDU: registers INC/DEC of its inputs on m_tick edges
      always @(posedge clk) begin
         if (m_tick) begin
            case (idu_opcode[g])
               INC16:   idu_result[g] <= idu_operand[g] + 16'd1;
               DEC16:   idu_result[g] <= idu_operand[g] - 16'd1;
               default: ;
            endcase
         end
      end
   end

   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         m_tick = (c == 3);
         c = (c + 1) % 4;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   int          ph    [2];
   int          midx  [2];
   idu_ops_t    mop   [2];
   logic [15:0] mopnd [2];
   logic [15:0] mexp  [2];
   logic [15:0] mlast [2];
   int          mptr  [2];
   bit          mfirst[2];

   task automatic model_step(input int d);
      int w;
      int idx;
      if (!rst_n) begin
         chk("rst_gnt", 32'(gnt[d]), 0);
         chk("rst_done", 32'(done[d]), 0);
         chk("rst_busy", 32'(busy[d]), 0);
         chk("rst_result", 32'(result[d]), 0);
         chk("rst_opcode", 32'(idu_opcode[d]), 32'(IDU_NOP));
         chk("rst_operand", 32'(idu_operand[d]), 0);
         ph[d] = 0; mptr[d] = 0; mlast[d] = 16'h0000;
         return;
      end
      case (ph[d])
         0: begin
            chk("idle_gnt", 32'(gnt[d]), 0);
            chk("idle_done", 32'(done[d]), 0);
            chk("idle_busy", 32'(busy[d]), 0);
            chk("idle_opcode", 32'(idu_opcode[d]), 32'(IDU_NOP));
            chk("idle_operand", 32'(idu_operand[d]), 0);
            chk("idle_result", 32'(result[d]), 32'(mlast[d]));
            w = -1;
            for (int k = 0; k < N; k++) begin
               idx = ((d == 0 ? mptr[d] : 0) + k) % N;
               if (w < 0 && req[d][idx] && req_op[d][idx] != IDU_NOP) w = idx;
            end
            if (w >= 0) begin
               midx[d]  = w;
               mop[d]   = req_op[d][w];
               mopnd[d] = req_operand[d][w];
               mexp[d]  = (mop[d] == INC16) ? mopnd[d] + 16'd1 : mopnd[d] - 16'd1;
               mfirst[d] = 1'b1;
               ph[d] = 1;
            end
         end
         1: begin
            chk("issue_gnt", 32'(gnt[d]), mfirst[d] ? (32'd1 << midx[d]) : 32'd0);
            chk("issue_done", 32'(done[d]), 0);
            chk("issue_busy", 32'(busy[d]), 1);
            chk("issue_opcode", 32'(idu_opcode[d]), 32'(mop[d]));
            chk("issue_operand", 32'(idu_operand[d]), 32'(mopnd[d]));
            chk("issue_result", 32'(result[d]), 32'(mlast[d]));
            mfirst[d] = 1'b0;
            if (m_tick) ph[d] = 2;
         end
         2: begin
            chk("cap_gnt", 32'(gnt[d]), 0);
            chk("cap_done", 32'(done[d]), 0);
            chk("cap_busy", 32'(busy[d]), 1);
            chk("cap_opcode", 32'(idu_opcode[d]), 32'(IDU_NOP));
            chk("cap_result", 32'(result[d]), 32'(mlast[d]));
            ph[d] = 3;
         end
         default: begin
            chk("resp_gnt", 32'(gnt[d]), 0);
            chk("resp_done", 32'(done[d]), 32'd1 << midx[d]);
            chk("resp_busy", 32'(busy[d]), 1);
            chk("resp_opcode", 32'(idu_opcode[d]), 32'(IDU_NOP));
            chk("resp_result", 32'(result[d]), 32'(mexp[d]));
            mlast[d] = mexp[d];
            if (d == 0) mptr[d] = (midx[d] + 1) % N;
            ph[d] = 0;
         end
      endcase
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) model_step(d);
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_any_done(input int d, output int idx, output logic [15:0] r);
      bit got;
      got = 1'b0; idx = -1; r = 16'h0000;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (done[d] != '0) begin
            got = 1'b1;
            r = result[d];
            for (int k = 0; k < N; k++) if (done[d][k]) idx = k;
         end
      end
      chk("done_seen", 32'(got), 1);
   endtask

   task automatic wait_gnt(input int d, input int i);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (gnt[d][i]) got = 1'b1;
      end
      chk("gnt_seen", 32'(got), 1);
   endtask

   task automatic drop_all(input int d);
      req[d] = '0;
      for (int k = 0; k < N; k++) req_op[d][k] = IDU_NOP;
   endtask

   task automatic single(input int d, input int i, input idu_ops_t op,
                         input logic [15:0] opnd, output int idx, output logic [15:0] r);
      @(posedge clk); #1;
      req[d][i] = 1'b1; req_op[d][i] = op; req_operand[d][i] = opnd;
      wait_any_done(d, idx, r);
      @(posedge clk); #1;
      drop_all(d);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int idx;
      logic [15:0] r;
      int gcnt, bcnt;
      bit mt;
      int exp_idx [5];
      logic [15:0] exp_res [5];

      for (int d = 0; d < 2; d++) begin
         drop_all(d);
         req_operand[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: single INC16
      single(0, 0, INC16, 16'h1234, idx, r);
      chk("t1_idx", 32'(idx), 0);
      chk("t1_result", 32'(r), 32'h1235);

      // 2: wrap both ways
      single(0, 1, INC16, 16'hFFFF, idx, r);
      chk("t2_inc_wrap", 32'(r), 32'h0000);
      single(0, 1, DEC16, 16'h0000, idx, r);
      chk("t2_dec_wrap", 32'(r), 32'hFFFF);

      // 5a: NOP request is ignored
      @(posedge clk); #1;
      req[0][2] = 1'b1; req_op[0][2] = IDU_NOP; req_operand[0][2] = 16'h5555;
      gcnt = 0; bcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (gnt[0] != '0) gcnt++;
         if (busy[0]) bcnt++;
      end
      chk("t5_nop_gnts", 32'(gcnt), 0);
      chk("t5_nop_busy", 32'(bcnt), 0);
      @(posedge clk); #1;
      drop_all(0);

      // 5b: operand/op changed after gnt have no effect
      @(posedge clk); #1;
      req[0][1] = 1'b1; req_op[0][1] = INC16; req_operand[0][1] = 16'h0100;
      wait_gnt(0, 1);
      #2;
      req_operand[0][1] = 16'h7777; req_op[0][1] = DEC16;
      wait_any_done(0, idx, r);
      chk("t5_latched", 32'(r), 32'h0101);
      @(posedge clk); #1;
      drop_all(0);

      // 6: move rr_ptr to 3, then reset in ISSUE and in CAPTURE
      single(0, 2, INC16, 16'h00AA, idx, r);
      chk("t6_pre", 32'(r), 32'h00AB);

      @(posedge clk); #1;
      req[0][0] = 1'b1; req_op[0][0] = INC16; req_operand[0][0] = 16'h0010;
      wait_gnt(0, 0);
      #2;
      rst_n = 1'b0;
      drop_all(0);
      @(negedge clk);
      chk("t6_issue_busy", 32'(busy[0]), 0);
      chk("t6_issue_done", 32'(done[0]), 0);
      chk("t6_issue_result", 32'(result[0]), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      @(posedge clk); #1;
      req[0][0] = 1'b1; req_op[0][0] = INC16; req_operand[0][0] = 16'h0020;
      wait_gnt(0, 0);
      mt = m_tick;
      for (int n = 0; n < 8 && !mt; n++) begin
         @(negedge clk);
         mt = m_tick;
      end
      chk("t6_mtick_seen", 32'(mt), 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      drop_all(0);
      @(negedge clk);
      chk("t6_cap_busy", 32'(busy[0]), 0);
      chk("t6_cap_done", 32'(done[0]), 0);
      chk("t6_cap_result", 32'(result[0]), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // rr_ptr back at 0: req 1 beats req 3
      @(posedge clk); #1;
      req[0][1] = 1'b1; req_op[0][1] = INC16; req_operand[0][1] = 16'h0001;
      req[0][3] = 1'b1; req_op[0][3] = INC16; req_operand[0][3] = 16'h0003;
      wait_any_done(0, idx, r);
      chk("t6_fresh_idx", 32'(idx), 1);
      chk("t6_fresh_result", 32'(r), 32'h0002);
      @(posedge clk); #1;
      drop_all(0);

      pulse_reset();

      // 3: round-robin, all four held
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         req[0][k] = 1'b1; req_op[0][k] = DEC16;
         req_operand[0][k] = 16'((k + 1) * 16'h1000 + k);
      end
      exp_idx = '{0, 1, 2, 3, 0};
      exp_res = '{16'h0FFF, 16'h2000, 16'h3001, 16'h4002, 16'h0FFF};
      for (int t = 0; t < 5; t++) begin
         wait_any_done(0, idx, r);
         chk("t3_rr_idx", 32'(idx), 32'(exp_idx[t]));
         chk("t3_rr_result", 32'(r), 32'(exp_res[t]));
      end
      @(posedge clk); #1;
      drop_all(0);

      // 4: fixed priority, same stimulus
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         req[1][k] = 1'b1; req_op[1][k] = DEC16;
         req_operand[1][k] = 16'((k + 1) * 16'h1000 + k);
      end
      for (int t = 0; t < 3; t++) begin
         wait_any_done(1, idx, r);
         chk("t4_fp_idx", 32'(idx), 0);
         chk("t4_fp_result", 32'(r), 32'h0FFF);
      end
      @(posedge clk); #1;
      req[1][0] = 1'b0; req_op[1][0] = IDU_NOP;
      wait_any_done(1, idx, r);
      chk("t4_fp_after_drop", 32'(idx), 1);
      chk("t4_fp_after_res", 32'(r), 32'h2000);
      @(posedge clk); #1;
      drop_all(1);

      repeat (8) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
